// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants and state encodings for the VGA sync controller.
//   - Default 640x480@60 Hz phase lengths (pixels / lines) and totals
//   - Counter widths for the raster counters and the pixel-rate divider
//   - Horizontal / vertical phase state encodings
//   - last_idx(): converts a phase boundary (count of items) to the index of
//     its final element at counter width
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned CLK_DIV_DEF  = 4;

    // Raster counter width (covers H_TOTAL = 800 and V_TOTAL = 525).
    localparam int unsigned CNT_W = 10;
    // Divider width (CLK_DIV up to 16 -> counter 0..15).
    localparam int unsigned DIV_W = 4;

    typedef enum logic [1:0] {
        H_ACT   = 2'd0,
        H_FRONT = 2'd1,
        H_SYNCS = 2'd2,
        H_BACK  = 2'd3
    } h_state_t;

    typedef enum logic [1:0] {
        V_ACT   = 2'd0,
        V_FRONT = 2'd1,
        V_SYNCS = 2'd2,
        V_BACK  = 2'd3
    } v_state_t;

    function automatic logic [CNT_W-1:0] last_idx(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// -----------------------------------------------------------------------------
// pixel_tick_gen
// Pixel-rate enable generator: a free-running 0..CLK_DIV-1 counter whose
// terminal count produces a registered one-clock pulse every CLK_DIV clocks.
// The first pulse appears after the CLK_DIV-th clock edge following reset.
// Ports:
//   i_clk         system clock
//   i_reset       synchronous, active-high reset
//   o_pixel_tick  one-clock pulse every CLK_DIV clocks
// -----------------------------------------------------------------------------
module pixel_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_pixel_tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_tick;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_div == DIV_LAST);
            r_div  <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    assign o_pixel_tick = r_tick;

endmodule

// File: rtl/vga_sync_controller.sv
// -----------------------------------------------------------------------------
// vga_sync_controller
// VGA raster sequencer. A pixel-rate enable advances a horizontal phase FSM;
// its end-of-line wrap advances a vertical phase FSM. Sync, video-active and
// frame-start outputs are registered decodes (one clock after the counters).
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   o_pixel_tick   one-clock pulse every CLK_DIV clocks
//   o_hcount       pixel column, 0..H_TOTAL-1
//   o_vcount       line, 0..V_TOTAL-1
//   o_hsync        SYNC_POL while in the horizontal sync phase
//   o_vsync        SYNC_POL while in the vertical sync phase
//   o_video_on     high inside the active window
//   o_frame_start  one-clock pulse in the clock after the raster wraps to (0,0)
//   o_frame_count  (VGA_FRAME_COUNT_EN only) 16-bit wrapping frame counter
// Optional feature macro: VGA_FRAME_COUNT_EN
// -----------------------------------------------------------------------------
module vga_sync_controller
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    output logic             o_pixel_tick,
    output logic [CNT_W-1:0] o_hcount,
    output logic [CNT_W-1:0] o_vcount,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_video_on,
    output logic             o_frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0]      o_frame_count
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Index of the last pixel/line of each phase.
    localparam logic [CNT_W-1:0] H_ACT_END  = last_idx(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_FP_END   = last_idx(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = last_idx(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_TOT_END  = last_idx(H_TOTAL);
    localparam logic [CNT_W-1:0] V_ACT_END  = last_idx(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_FP_END   = last_idx(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = last_idx(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_TOT_END  = last_idx(V_TOTAL);

    logic             w_pixel_tick;
    h_state_t         r_h_state;
    h_state_t         w_h_state_d;
    v_state_t         r_v_state;
    v_state_t         w_v_state_d;
    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] w_hcount_d;
    logic [CNT_W-1:0] r_vcount;
    logic [CNT_W-1:0] w_vcount_d;
    logic             w_line_adv;
    logic             w_frame_wrap;
    logic             r_frame_wrap;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_frame_start;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .o_pixel_tick (w_pixel_tick)
    );

    // Horizontal phase FSM: next state and column counter.
    always_comb begin
        w_h_state_d = r_h_state;
        w_hcount_d  = r_hcount;
        w_line_adv  = 1'b0;
        if (w_pixel_tick) begin
            w_hcount_d = r_hcount + 1'b1;
            unique case (r_h_state)
                H_ACT:   if (r_hcount == H_ACT_END)  w_h_state_d = H_FRONT;
                H_FRONT: if (r_hcount == H_FP_END)   w_h_state_d = H_SYNCS;
                H_SYNCS: if (r_hcount == H_SYNC_END) w_h_state_d = H_BACK;
                H_BACK: begin
                    if (r_hcount == H_TOT_END) begin
                        w_h_state_d = H_ACT;
                        w_hcount_d  = '0;
                        w_line_adv  = 1'b1;
                    end
                end
                default: begin
                    w_h_state_d = H_ACT;
                    w_hcount_d  = '0;
                end
            endcase
        end
    end

    // Vertical phase FSM: advances only on the end-of-line wrap.
    always_comb begin
        w_v_state_d  = r_v_state;
        w_vcount_d   = r_vcount;
        w_frame_wrap = 1'b0;
        if (w_line_adv) begin
            w_vcount_d = r_vcount + 1'b1;
            unique case (r_v_state)
                V_ACT:   if (r_vcount == V_ACT_END)  w_v_state_d = V_FRONT;
                V_FRONT: if (r_vcount == V_FP_END)   w_v_state_d = V_SYNCS;
                V_SYNCS: if (r_vcount == V_SYNC_END) w_v_state_d = V_BACK;
                V_BACK: begin
                    if (r_vcount == V_TOT_END) begin
                        w_v_state_d  = V_ACT;
                        w_vcount_d   = '0;
                        w_frame_wrap = 1'b1;
                    end
                end
                default: begin
                    w_v_state_d = V_ACT;
                    w_vcount_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_h_state <= H_ACT;
            r_v_state <= V_ACT;
            r_hcount  <= '0;
            r_vcount  <= '0;
        end else begin
            r_h_state <= w_h_state_d;
            r_v_state <= w_v_state_d;
            r_hcount  <= w_hcount_d;
            r_vcount  <= w_vcount_d;
        end
    end

    // Output decodes lag the counters by one clock. frame_start needs the
    // extra r_frame_wrap stage so it lands in the same clock as the first
    // decode of (0,0).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_frame_wrap  <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_wrap  <= w_frame_wrap;
            r_hsync       <= (r_h_state == H_SYNCS) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (r_v_state == V_SYNCS) ? SYNC_POL : ~SYNC_POL;
            r_video_on    <= (r_h_state == H_ACT) && (r_v_state == V_ACT);
            r_frame_start <= r_frame_wrap;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    // Increments in the same clock frame_start rises.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_frame_count <= '0;
        end else if (r_frame_wrap) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign o_frame_count = r_frame_count;
`endif

    assign o_pixel_tick  = w_pixel_tick;
    assign o_hcount      = r_hcount;
    assign o_vcount      = r_vcount;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_video_on    = r_video_on;
    assign o_frame_start = r_frame_start;

endmodule
